// File: rtl/lcd_char_display.sv
// HD44780-class character LCD controller: power-up wait, init command sequence,
// then per-row refresh of a ROWS x COLS text frame through an ena/done byte writer.
module lcd_char_display #(
  parameter int ROWS       = 2,
  parameter int COLS       = 16,
  parameter int INIT_WAIT  = 50000,
  parameter int CLEAR_WAIT = 2000,
  parameter int PARTIAL    = 1
) (
  input  logic                   clk_1MHz,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic [ROWS*COLS*8-1:0] text,
  input  logic                   done_write,
  output logic [7:0]             data,
  output logic                   cmd_data,
  output logic                   ena_write,
  output logic                   busy,
  output logic                   init_done
);

  localparam int FRAME_W  = ROWS * COLS * 8;
  localparam int ROW_W    = COLS * 8;
  localparam int MAX_WAIT = (INIT_WAIT > CLEAR_WAIT) ? INIT_WAIT : CLEAR_WAIT;
  localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam int COL_W    = $clog2(COLS + 1);

  typedef enum logic [3:0] {
    ST_PWRUP, ST_INIT_ISSUE, ST_INIT_WAIT, ST_IDLE, ST_LOAD,
    ST_ROW_CHK, ST_ADDR_ISSUE, ST_CHR_ISSUE, ST_WAIT_DONE, ST_DELAY
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         init_idx_q, init_idx_d;
  logic [1:0]         row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic               chr_phase_q, chr_phase_d;
  logic               pending_q, pending_d;
  logic               first_q, first_d;
  logic               done_q, done_d;
  logic [7:0]         data_q, data_d;
  logic               cmd_data_q, cmd_data_d;
  logic               ena_write_q, ena_write_d;
  logic               busy_q, busy_d;
  logic               init_done_q, init_done_d;
  logic [FRAME_W-1:0] shadow_q, shadow_d;
  logic [FRAME_W-1:0] last_q, last_d;
  logic               advance_row;
  int unsigned        cnt_ext;

  assign cnt_ext = 32'(cnt_q);

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h33;
      3'd1:    return 8'h32;
      3'd2:    return 8'h28;
      3'd3:    return 8'h0C;
      3'd4:    return 8'h06;
      default: return 8'h01;
    endcase
  endfunction

  function automatic logic [7:0] row_base(input logic [1:0] r);
    case (r)
      2'd0:    return 8'h00;
      2'd1:    return 8'h40;
      2'd2:    return 8'(COLS);
      default: return 8'(64 + COLS);
    endcase
  endfunction

  function automatic logic [7:0] char_at(input logic [FRAME_W-1:0] f, input int r, input int c);
    return f[(ROWS*COLS-1-(r*COLS+c))*8 +: 8];
  endfunction

  function automatic logic [ROW_W-1:0] row_of(input logic [FRAME_W-1:0] f, input int r);
    return f[(ROWS-1-r)*ROW_W +: ROW_W];
  endfunction

  always_comb begin
    // NOTE: every _d starts from its _q so no branch below can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_idx_d  = init_idx_q;
    row_d       = row_q;
    col_d       = col_q;
    chr_phase_d = chr_phase_q;
    pending_d   = pending_q;
    first_d     = first_q;
    data_d      = data_q;
    cmd_data_d  = cmd_data_q;
    ena_write_d = 1'b0;
    busy_d      = busy_q;
    init_done_d = init_done_q;
    shadow_d    = shadow_q;
    last_d      = last_q;
    advance_row = 1'b0;
    // done is registered so the next byte is issued one cycle after it is seen
    done_d      = done_write && (state_q == ST_INIT_WAIT || state_q == ST_WAIT_DONE);

    if (ena && (state_q inside {ST_ROW_CHK, ST_ADDR_ISSUE, ST_CHR_ISSUE, ST_WAIT_DONE}))
      pending_d = 1'b1;

    case (state_q)
      ST_PWRUP: begin
        if (cnt_ext + 32'd1 >= INIT_WAIT) begin
          cnt_d       = '0;
          init_idx_d  = 3'd0;
          state_d     = ST_INIT_ISSUE;
          data_d      = init_cmd(3'd0);
          cmd_data_d  = 1'b0;
          ena_write_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_INIT_ISSUE: state_d = ST_INIT_WAIT;
      ST_INIT_WAIT: begin
        if (done_q) begin
          if (init_idx_q == 3'd5) begin
            cnt_d   = '0;
            state_d = ST_DELAY;
          end else begin
            init_idx_d  = init_idx_q + 3'd1;
            state_d     = ST_INIT_ISSUE;
            data_d      = init_cmd(init_idx_q + 3'd1);
            cmd_data_d  = 1'b0;
            ena_write_d = 1'b1;
          end
        end
      end
      ST_DELAY: begin
        if (cnt_ext + 32'd1 >= CLEAR_WAIT) begin
          cnt_d       = '0;
          busy_d      = 1'b0;
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (ena || pending_q) begin
          busy_d  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        shadow_d  = text;
        pending_d = 1'b0;
        row_d     = 2'd0;
        col_d     = '0;
        state_d   = ST_ROW_CHK;
      end
      ST_ROW_CHK: begin
        if (first_q || PARTIAL == 0 ||
            row_of(shadow_q, int'(row_q)) != row_of(last_q, int'(row_q))) begin
          chr_phase_d = 1'b0;
          col_d       = '0;
          state_d     = ST_ADDR_ISSUE;
          data_d      = 8'h80 | row_base(row_q);
          cmd_data_d  = 1'b0;
          ena_write_d = 1'b1;
        end else begin
          advance_row = 1'b1;
        end
      end
      ST_ADDR_ISSUE, ST_CHR_ISSUE: state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (done_q) begin
          if (!chr_phase_q) begin
            chr_phase_d = 1'b1;
            col_d       = '0;
            state_d     = ST_CHR_ISSUE;
            data_d      = char_at(shadow_q, int'(row_q), 0);
            cmd_data_d  = 1'b1;
            ena_write_d = 1'b1;
          end else if (col_q == COL_W'(COLS - 1)) begin
            col_d       = '0;
            last_d[(ROWS-1-int'(row_q))*ROW_W +: ROW_W] = row_of(shadow_q, int'(row_q));
            advance_row = 1'b1;
          end else begin
            col_d       = col_q + COL_W'(1);
            state_d     = ST_CHR_ISSUE;
            data_d      = char_at(shadow_q, int'(row_q), int'(col_q) + 1);
            cmd_data_d  = 1'b1;
            ena_write_d = 1'b1;
          end
        end
      end
      default: state_d = ST_PWRUP;
    endcase

    // Shared by skipped rows and finished rows: next row, or close the frame
    if (advance_row) begin
      if (row_q == 2'(ROWS - 1)) begin
        first_d = 1'b0;
        if (pending_d) begin
          state_d = ST_LOAD;
        end else begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end else begin
        row_d   = row_q + 2'd1;
        state_d = ST_ROW_CHK;
      end
    end
  end

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PWRUP;
      cnt_q       <= '0;
      init_idx_q  <= 3'd0;
      row_q       <= 2'd0;
      col_q       <= '0;
      chr_phase_q <= 1'b0;
      pending_q   <= 1'b0;
      first_q     <= 1'b1;
      done_q      <= 1'b0;
      data_q      <= 8'h00;
      cmd_data_q  <= 1'b0;
      ena_write_q <= 1'b0;
      busy_q      <= 1'b1;
      init_done_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_idx_q  <= init_idx_d;
      row_q       <= row_d;
      col_q       <= col_d;
      chr_phase_q <= chr_phase_d;
      pending_q   <= pending_d;
      first_q     <= first_d;
      done_q      <= done_d;
      data_q      <= data_d;
      cmd_data_q  <= cmd_data_d;
      ena_write_q <= ena_write_d;
      busy_q      <= busy_d;
      init_done_q <= init_done_d;
    end
  end

  // NOTE: frame storage is left unreset; its contents are never used while first_q is set.
  always_ff @(posedge clk_1MHz) begin
    shadow_q <= shadow_d;
    last_q   <= last_d;
  end

  assign data      = data_q;
  assign cmd_data  = cmd_data_q;
  assign ena_write = ena_write_q;
  assign busy      = busy_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_lcd_char_display.sv
// Scoreboard bench for lcd_char_display: three instances (2x16 partial, 2x16 full
// refresh, 4x20) each driven by a writer model answering done ~5 cycles after ena_write.
module tb_lcd_char_display;

  localparam int IW = 100;
  localparam int CW = 20;
  localparam logic [7:0] INIT_SEQ [6] = '{8'h33, 8'h32, 8'h28, 8'h0C, 8'h06, 8'h01};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic rst_n_a, rst_n_bc;
  logic ena_a, ena_b, ena_c;
  logic inj_a;
  logic [255:0] text_a, text_b;
  logic [639:0] text_c;
  logic mdone_a, mdone_b, mdone_c;
  logic done_a, done_b, done_c;
  logic [7:0] data_a, data_b, data_c;
  logic cmd_a, cmd_b, cmd_c, ew_a, ew_b, ew_c;
  logic busy_a, busy_b, busy_c, idn_a, idn_b, idn_c;

  assign done_a = mdone_a | inj_a;
  assign done_b = mdone_b;
  assign done_c = mdone_c;

  lcd_char_display #(.ROWS(2), .COLS(16), .INIT_WAIT(IW), .CLEAR_WAIT(CW), .PARTIAL(1)) dut_a (
    .clk_1MHz(clk), .rst_n(rst_n_a), .ena(ena_a), .text(text_a), .done_write(done_a),
    .data(data_a), .cmd_data(cmd_a), .ena_write(ew_a), .busy(busy_a), .init_done(idn_a));

  lcd_char_display #(.ROWS(2), .COLS(16), .INIT_WAIT(IW), .CLEAR_WAIT(CW), .PARTIAL(0)) dut_b (
    .clk_1MHz(clk), .rst_n(rst_n_bc), .ena(ena_b), .text(text_b), .done_write(done_b),
    .data(data_b), .cmd_data(cmd_b), .ena_write(ew_b), .busy(busy_b), .init_done(idn_b));

  lcd_char_display #(.ROWS(4), .COLS(20), .INIT_WAIT(IW), .CLEAR_WAIT(CW), .PARTIAL(1)) dut_c (
    .clk_1MHz(clk), .rst_n(rst_n_bc), .ena(ena_c), .text(text_c), .done_write(done_c),
    .data(data_c), .cmd_data(cmd_c), .ena_write(ew_c), .busy(busy_c), .init_done(idn_c));

  // Writer models: done pulses one cycle, about 5 cycles after ena_write is seen
  int wcnt_a, wcnt_b, wcnt_c;
  always @(posedge clk or negedge rst_n_a)
    if (!rst_n_a) begin wcnt_a <= 0; mdone_a <= 1'b0; end
    else begin
      mdone_a <= (wcnt_a == 1);
      if (wcnt_a != 0) wcnt_a <= wcnt_a - 1; else if (ew_a) wcnt_a <= 5;
    end
  always @(posedge clk or negedge rst_n_bc)
    if (!rst_n_bc) begin wcnt_b <= 0; mdone_b <= 1'b0; wcnt_c <= 0; mdone_c <= 1'b0; end
    else begin
      mdone_b <= (wcnt_b == 1);
      if (wcnt_b != 0) wcnt_b <= wcnt_b - 1; else if (ew_b) wcnt_b <= 5;
      mdone_c <= (wcnt_c == 1);
      if (wcnt_c != 0) wcnt_c <= wcnt_c - 1; else if (ew_c) wcnt_c <= 5;
    end

  logic [8:0] exp_a[$], exp_b[$], exp_c[$];
  int pulses [3];
  int bfall_a = 0;
  int last_done_a = 0;
  logic busy_prev_a = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic mon(input int i, input logic [8:0] act);
    logic [8:0] e;
    bit have;
    e = '0;
    pulses[i]++;
    case (i)
      0:       begin have = exp_a.size() > 0; if (have) e = exp_a.pop_front(); end
      1:       begin have = exp_b.size() > 0; if (have) e = exp_b.pop_front(); end
      default: begin have = exp_c.size() > 0; if (have) e = exp_c.pop_front(); end
    endcase
    if (!have) begin
      tests++;
      fails++;
      $display("FAIL unexpected_byte dut%0d: got %03h, expected no byte", i, act);
    end else begin
      check($sformatf("byte_dut%0d", i), 32'(act), 32'(e));
    end
  endtask

  // Monitor: pops the scoreboard on every ena_write pulse
  always @(negedge clk) begin
    if (rst_n_a && ew_a) mon(0, {cmd_a, data_a});
    if (rst_n_bc && ew_b) mon(1, {cmd_b, data_b});
    if (rst_n_bc && ew_c) mon(2, {cmd_c, data_c});
    if (done_a) last_done_a = cyc;
    if (busy_prev_a && !busy_a) bfall_a++;
    busy_prev_a = busy_a;
  end

  function automatic logic busy_of(input int i);
    case (i) 0: return busy_a; 1: return busy_b; default: return busy_c; endcase
  endfunction

  function automatic logic idn_of(input int i);
    case (i) 0: return idn_a; 1: return idn_b; default: return idn_c; endcase
  endfunction

  function automatic int qsize(input int i);
    case (i) 0: return exp_a.size(); 1: return exp_b.size(); default: return exp_c.size(); endcase
  endfunction

  task automatic push(input int i, input logic [8:0] v);
    case (i) 0: exp_a.push_back(v); 1: exp_b.push_back(v); default: exp_c.push_back(v); endcase
  endtask

  task automatic push_init(input int i);
    for (int k = 0; k < 6; k++) push(i, {1'b0, INIT_SEQ[k]});
  endtask

  task automatic push_row(input int i, input logic [7:0] addr, input string s);
    push(i, {1'b0, addr});
    for (int c = 0; c < s.len(); c++) push(i, {1'b1, s[c]});
  endtask

  task automatic set_row(input int i, input int r, input string s);
    for (int c = 0; c < s.len(); c++)
      case (i)
        0:       text_a[(31 - (r*16 + c))*8 +: 8] = s[c];
        1:       text_b[(31 - (r*16 + c))*8 +: 8] = s[c];
        default: text_c[(79 - (r*20 + c))*8 +: 8] = s[c];
      endcase
  endtask

  task automatic pulse_ena(input int i);
    @(negedge clk);
    case (i) 0: ena_a = 1'b1; 1: ena_b = 1'b1; default: ena_c = 1'b1; endcase
    @(negedge clk);
    ena_a = 1'b0; ena_b = 1'b0; ena_c = 1'b0;
  endtask

  task automatic wait_init(input int i, input string name);
    int n = 0;
    while (!idn_of(i) && n < 2000) begin @(negedge clk); n++; end
    check({name, "_init_done"}, 32'(idn_of(i)), 32'd1);
    check({name, "_busy_after_init"}, 32'(busy_of(i)), 32'd0);
    check({name, "_init_bytes_left"}, 32'(qsize(i)), 32'd0);
  endtask

  task automatic wait_idle(input int i, input string name);
    int n = 0;
    while (busy_of(i) && n < 3000) begin @(negedge clk); n++; end
    check({name, "_busy_low"}, 32'(busy_of(i)), 32'd0);
  endtask

  task automatic wait_pulses(input int i, input int target, input string name);
    int n = 0;
    while (pulses[i] < target && n < 3000) begin @(negedge clk); n++; end
    check({name, "_reached"}, 32'(pulses[i] >= target), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, bf0, n, nchar;
    pulses = '{0, 0, 0};
    rst_n_a = 1'b0; rst_n_bc = 1'b0;
    ena_a = 1'b0; ena_b = 1'b0; ena_c = 1'b0; inj_a = 1'b0;
    text_a = '0; text_b = '0; text_c = '0;
    repeat (3) @(negedge clk);

    check("rst_data", 32'(data_a), 32'h00);
    check("rst_cmd_data", 32'(cmd_a), 32'd0);
    check("rst_ena_write", 32'(ew_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd1);
    check("rst_init_done", 32'(idn_a), 32'd0);

    push_init(0); push_init(1); push_init(2);
    rst_n_a = 1'b1; rst_n_bc = 1'b1;
    wait_init(0, "a");
    check("a_clear_wait_ge20", 32'((cyc - last_done_a) >= CW), 32'd1);
    wait_init(1, "b");
    wait_init(2, "c");

    // First frame with start-latency checks
    set_row(0, 0, "HELLO WORLD     ");
    set_row(0, 1, "TEMP 04.5C      ");
    push_row(0, 8'h80, "HELLO WORLD     ");
    push_row(0, 8'hC0, "TEMP 04.5C      ");
    p0 = pulses[0];
    pulse_ena(0);
    check("start_busy_k", 32'(busy_a), 32'd1);
    @(negedge clk); check("start_ew_k1", 32'(ew_a), 32'd0);
    @(negedge clk); check("start_ew_k2", 32'(ew_a), 32'd1);
    wait_idle(0, "frame1");
    check("frame1_pulses", 32'(pulses[0] - p0), 32'd34);
    check("frame1_left", 32'(qsize(0)), 32'd0);

    // Partial refresh: only row 1 changes
    set_row(0, 1, "TEMP 00.5C      ");
    push_row(0, 8'hC0, "TEMP 00.5C      ");
    p0 = pulses[0];
    pulse_ena(0);
    wait_idle(0, "partial");
    check("partial_pulses", 32'(pulses[0] - p0), 32'd17);

    // Unchanged frame: ROWS+1 busy cycles, no bytes
    p0 = pulses[0];
    pulse_ena(0);
    n = 0;
    while (busy_a && n < 50) begin n++; @(negedge clk); end
    check("nochange_busy_cycles", 32'(n), 32'd3);
    check("nochange_pulses", 32'(pulses[0] - p0), 32'd0);

    // Queued requests: two ena pulses mid-frame produce one replay
    set_row(0, 1, "TEMP 11.0C      ");
    push_row(0, 8'hC0, "TEMP 11.0C      ");
    p0 = pulses[0];
    bf0 = bfall_a;
    pulse_ena(0);
    wait_pulses(0, p0 + 5, "queue_mid1");
    set_row(0, 0, "GOODBYE WORLD   ");
    push_row(0, 8'h80, "GOODBYE WORLD   ");
    pulse_ena(0);
    wait_pulses(0, p0 + 10, "queue_mid2");
    pulse_ena(0);
    wait_idle(0, "queue");
    check("queue_pulses", 32'(pulses[0] - p0), 32'd34);
    check("queue_busy_falls", 32'(bfall_a - bf0), 32'd1);
    repeat (40) @(negedge clk);
    check("queue_single_replay", 32'(pulses[0] - p0), 32'd34);
    check("queue_left", 32'(qsize(0)), 32'd0);

    // Spurious done in IDLE
    p0 = pulses[0];
    @(negedge clk); inj_a = 1'b1;
    @(negedge clk); inj_a = 1'b0;
    repeat (10) @(negedge clk);
    check("spurious_busy", 32'(busy_a), 32'd0);
    check("spurious_pulses", 32'(pulses[0] - p0), 32'd0);
    check("spurious_data_held", 32'({cmd_a, data_a}), 32'h120);

    // Reset during the 8th character
    set_row(0, 0, "RESET TEST 0123 ");
    push_row(0, 8'h80, "RESET TEST 0123 ");
    pulse_ena(0);
    nchar = 0; n = 0;
    while (nchar < 8 && n < 2000) begin
      @(negedge clk); n++;
      if (ew_a && cmd_a) nchar++;
    end
    check("midreset_reached_char8", 32'(nchar), 32'd8);
    rst_n_a = 1'b0;
    #1;
    check("midreset_ena_write", 32'(ew_a), 32'd0);
    check("midreset_busy", 32'(busy_a), 32'd1);
    check("midreset_init_done", 32'(idn_a), 32'd0);
    check("midreset_data", 32'(data_a), 32'h00);
    exp_a.delete();
    push_init(0);
    repeat (5) @(negedge clk);
    rst_n_a = 1'b1;
    wait_init(0, "a_reinit");
    push_row(0, 8'h80, "RESET TEST 0123 ");
    push_row(0, 8'hC0, "TEMP 11.0C      ");
    p0 = pulses[0];
    pulse_ena(0);
    wait_idle(0, "after_reset");
    check("after_reset_pulses", 32'(pulses[0] - p0), 32'd34);

    // Full refresh instance: every frame rewrites every row
    set_row(1, 0, "HELLO WORLD     ");
    set_row(1, 1, "TEMP 04.5C      ");
    for (int f = 0; f < 2; f++) begin
      push_row(1, 8'h80, "HELLO WORLD     ");
      push_row(1, 8'hC0, "TEMP 04.5C      ");
      p0 = pulses[1];
      pulse_ena(1);
      wait_idle(1, "full");
      check($sformatf("full_frame%0d_pulses", f), 32'(pulses[1] - p0), 32'd34);
    end

    // 4x20 geometry
    set_row(2, 0, "ROW ZERO ABCDEFGHIJK");
    set_row(2, 1, "ROW ONE  0123456789!");
    set_row(2, 2, "ROW TWO  abcdefghijk");
    set_row(2, 3, "ROW THREE 9876543210");
    push_row(2, 8'h80, "ROW ZERO ABCDEFGHIJK");
    push_row(2, 8'hC0, "ROW ONE  0123456789!");
    push_row(2, 8'h94, "ROW TWO  abcdefghijk");
    push_row(2, 8'hD4, "ROW THREE 9876543210");
    p0 = pulses[2];
    pulse_ena(2);
    wait_idle(2, "geom");
    check("geom_pulses", 32'(pulses[2] - p0), 32'd84);

    repeat (10) @(negedge clk);
    check("end_left_a", 32'(qsize(0)), 32'd0);
    check("end_left_b", 32'(qsize(1)), 32'd0);
    check("end_left_c", 32'(qsize(2)), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
